// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory-access stage: load-op one-hot layout,
// CP0 exception codes and GPR byte-write-enable encodings.
package mem_stage_pkg;

  localparam int LOAD_OP_WD = 7;

  // One-hot load_op bit positions, {lwr,lwl,lw,lhu,lh,lbu,lb}
  localparam int LB  = 0;
  localparam int LBU = 1;
  localparam int LH  = 2;
  localparam int LHU = 3;
  localparam int LW  = 4;
  localparam int LWL = 5;
  localparam int LWR = 6;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam logic [3:0] RF_WE_NONE = 4'b0000;
  localparam logic [3:0] RF_WE_ALL  = 4'b1111;

  function automatic logic [3:0] lwl_we(input logic [1:0] a);
    return RF_WE_ALL << ~a;
  endfunction

  function automatic logic [3:0] lwr_we(input logic [1:0] a);
    return RF_WE_ALL >> a;
  endfunction

endpackage

// File: rtl/mem_stage_sram_like_if.sv
// EX->MS->WB pipeline bus, SRAM-like data response, flush and forwarding
// signals of the memory stage; slave is the stage, master is its environment.
interface mem_stage_sram_like_if #(
  parameter int PAYLOAD_WD = 64
);
  logic                  es_to_ms_valid;
  logic                  ms_allowin;
  logic [31:0]           es_pc;
  logic [31:0]           es_alu_result;
  logic [6:0]            es_load_op;
  logic                  es_mem_req;
  logic                  es_gr_we;
  logic [4:0]            es_dest;
  logic                  es_ex;
  logic [PAYLOAD_WD-1:0] es_payload;
  logic                  es_req_inflight;
  logic                  data_sram_data_ok;
  logic [31:0]           data_sram_rdata;
  logic                  ws_allowin;
  logic                  ms_to_ws_valid;
  logic [31:0]           ms_pc;
  logic [31:0]           ms_result;
  logic [3:0]            ms_rf_we;
  logic [4:0]            ms_dest;
  logic                  ms_ex;
  logic [PAYLOAD_WD-1:0] ms_payload;
  logic                  ms_valid;
  logic                  ms_fwd_valid;
  logic                  ms_fwd_stall;
  logic [4:0]            ms_fwd_dest;
  logic [31:0]           ms_fwd_data;
  logic                  handle_ex;

  modport slave (
    input  es_to_ms_valid, es_pc, es_alu_result, es_load_op, es_mem_req,
           es_gr_we, es_dest, es_ex, es_payload, es_req_inflight,
           data_sram_data_ok, data_sram_rdata, ws_allowin, handle_ex,
    output ms_allowin, ms_to_ws_valid, ms_pc, ms_result, ms_rf_we, ms_dest,
           ms_ex, ms_payload, ms_valid, ms_fwd_valid, ms_fwd_stall,
           ms_fwd_dest, ms_fwd_data
  );

  modport master (
    output es_to_ms_valid, es_pc, es_alu_result, es_load_op, es_mem_req,
           es_gr_we, es_dest, es_ex, es_payload, es_req_inflight,
           data_sram_data_ok, data_sram_rdata, ws_allowin, handle_ex,
    input  ms_allowin, ms_to_ws_valid, ms_pc, ms_result, ms_rf_we, ms_dest,
           ms_ex, ms_payload, ms_valid, ms_fwd_valid, ms_fwd_stall,
           ms_fwd_dest, ms_fwd_data
  );

endinterface

// File: rtl/mem_load_align.sv
// Combinational load-data alignment and extension, including the partial
// byte-enables of LWL/LWR. Non-loads return zero data with {4{gr_we}}.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0]           rdata,
  input  logic [1:0]            addr_low,
  input  logic [LOAD_OP_WD-1:0] load_op,
  input  logic                  gr_we,
  output logic [31:0]           result,
  output logic [3:0]            rf_we
);

  logic [31:0]        shifted_r;
  logic [31:0]        shifted_l;
  logic signed [7:0]  sel_byte;
  logic signed [15:0] sel_half;

  always_comb begin
    shifted_r = rdata >> {addr_low, 3'b000};
    shifted_l = rdata << {~addr_low, 3'b000};
    sel_byte  = shifted_r[7:0];
    sel_half  = addr_low[1] ? rdata[31:16] : rdata[15:0];
    result    = 32'h0;
    rf_we     = {4{gr_we}};
    if (load_op[LB])       result = {{24{sel_byte[7]}}, sel_byte};
    else if (load_op[LBU]) result = {24'h0, sel_byte};
    else if (load_op[LH])  result = {{16{sel_half[15]}}, sel_half};
    else if (load_op[LHU]) result = {16'h0, sel_half};
    else if (load_op[LW])  result = rdata;
    else if (load_op[LWL]) begin
      result = shifted_l;
      rf_we  = lwl_we(addr_low) & {4{gr_we}};
    end else if (load_op[LWR]) begin
      result = shifted_r;
      rf_we  = lwr_we(addr_low) & {4{gr_we}};
    end
  end

endmodule

// File: rtl/mem_stage_sram_like.sv
// MEM stage for a variable-latency SRAM-like data port: holds loads until
// data_ok, buffers rdata under WB stall, drops flushed responses. Macro MS_FWD_EN.
module mem_stage_sram_like
  import mem_stage_pkg::*;
#(
  parameter int PAYLOAD_WD = 64,
  parameter int MAX_CANCEL = 3
) (
  input logic                  clk,
  input logic                  reset,
  mem_stage_sram_like_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_CANCEL + 1);
  localparam logic [CNT_W:0]   CNT_LIMIT = (CNT_W + 1)'(MAX_CANCEL);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_CANCEL);

  logic                  vld_p1;
  logic [31:0]           pc_p1;
  logic [31:0]           alu_result_p1;
  logic [LOAD_OP_WD-1:0] load_op_p1;
  logic                  mem_req_p1;
  logic                  gr_we_p1;
  logic [4:0]            dest_p1;
  logic                  ex_p1;
  logic [PAYLOAD_WD-1:0] payload_p1;

  logic             buf_valid;
  logic [31:0]      buf_data;
  logic [CNT_W-1:0] cancel_cnt;
  logic [CNT_W:0]   cnt_next;

  logic        waiting, live_ok, ready_go, allowin, to_ws_valid, is_load;
  logic [31:0] load_data, align_result, result;
  logic [3:0]  align_we;

  assign waiting     = vld_p1 && mem_req_p1 && !ex_p1 && !buf_valid;
  assign live_ok     = bus.data_sram_data_ok && (cancel_cnt == '0);
  assign ready_go    = !mem_req_p1 || ex_p1 || buf_valid || live_ok;
  assign allowin     = !vld_p1 || (ready_go && bus.ws_allowin);
  assign to_ws_valid = vld_p1 && ready_go;
  assign is_load     = |load_op_p1;
  assign load_data   = buf_valid ? buf_data : bus.data_sram_rdata;

  // EX -> MS boundary
  always_ff @(posedge clk) begin
    if (reset || bus.handle_ex) vld_p1 <= 1'b0;
    else if (allowin)           vld_p1 <= bus.es_to_ms_valid;
  end

  always_ff @(posedge clk) begin
    if (bus.es_to_ms_valid && allowin) begin
      pc_p1         <= bus.es_pc;
      alu_result_p1 <= bus.es_alu_result;
      load_op_p1    <= bus.es_load_op;
      mem_req_p1    <= bus.es_mem_req;
      gr_we_p1      <= bus.es_gr_we;
      dest_p1       <= bus.es_dest;
      ex_p1         <= bus.es_ex;
      payload_p1    <= bus.es_payload;
    end
  end

  // Response held here while WB stalls, so data_ok is consumed exactly once
  always_ff @(posedge clk) begin
    if (reset || bus.handle_ex)            buf_valid <= 1'b0;
    else if (to_ws_valid && bus.ws_allowin) buf_valid <= 1'b0;
    else if (waiting && live_ok)           buf_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (waiting && live_ok && !bus.ws_allowin) buf_data <= bus.data_sram_rdata;
  end

  always_comb begin
    cnt_next = {1'b0, cancel_cnt};
    if (bus.data_sram_data_ok && (cancel_cnt != '0))
      cnt_next = cnt_next - {{CNT_W{1'b0}}, 1'b1};
    if (bus.handle_ex)
      cnt_next = cnt_next + {{CNT_W{1'b0}}, waiting && !live_ok}
                          + {{CNT_W{1'b0}}, bus.es_req_inflight};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cancel_cnt <= '0;
    end else begin
      assert (cnt_next <= CNT_LIMIT);
      cancel_cnt <= (cnt_next > CNT_LIMIT) ? CNT_SAT : cnt_next[CNT_W-1:0];
    end
  end

  mem_load_align u_align (
    .rdata    (load_data),
    .addr_low (alu_result_p1[1:0]),
    .load_op  (load_op_p1),
    .gr_we    (gr_we_p1),
    .result   (align_result),
    .rf_we    (align_we)
  );

  assign result = is_load ? align_result : alu_result_p1;

  assign bus.ms_allowin     = allowin;
  assign bus.ms_to_ws_valid = to_ws_valid;
  assign bus.ms_valid       = vld_p1;
  assign bus.ms_pc          = pc_p1;
  assign bus.ms_result      = result;
  assign bus.ms_rf_we       = ex_p1 ? RF_WE_NONE : align_we;
  assign bus.ms_dest        = dest_p1;
  assign bus.ms_ex          = ex_p1;
  assign bus.ms_payload     = payload_p1;

`ifdef MS_FWD_EN
  assign bus.ms_fwd_valid = vld_p1 && gr_we_p1 && !ex_p1 && (dest_p1 != 5'd0);
  assign bus.ms_fwd_stall = vld_p1 && is_load && !ready_go;
  assign bus.ms_fwd_dest  = dest_p1;
  assign bus.ms_fwd_data  = result;
`else
  assign bus.ms_fwd_valid = 1'b0;
  assign bus.ms_fwd_stall = 1'b0;
  assign bus.ms_fwd_dest  = 5'd0;
  assign bus.ms_fwd_data  = 32'd0;
`endif

endmodule

// File: doc/mem_stage_sram_like.md
Name: mem_stage_sram_like

Overview:
- Memory-access pipeline stage for the 5-stage MIPS core. Sits between EX and WB.
- Targets a variable-latency SRAM-like data port (data_ok handshake) instead of a fixed one-cycle SRAM.
- Holds the instruction until its load response arrives and buffers rdata while WB stalls.
- Aligns and extends load data, including LWL/LWR byte-enables.
- Discards stale responses belonging to instructions flushed by an exception.

Parameters:
PAYLOAD_WD, 64, width of opaque sideband passed EX->WB unchanged (cp0 addr/wdata, eret/mtc0, bd, badvaddr, exccode).
MAX_CANCEL, 3, max outstanding responses to discard; cancel counter width = $clog2(MAX_CANCEL+1).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
es_to_ms_valid  in  1  EX holds valid instruction
ms_allowin  out  1  MS accepts from EX this cycle
es_pc  in  32  instruction PC
es_alu_result  in  32  ALU result / memory address
es_load_op  in  7  one-hot {lwr,lwl,lw,lhu,lh,lbu,lb}; all-zero = not a load
es_mem_req  in  1  instruction issued a data request that will return data_ok
es_gr_we  in  1  writes GPR
es_dest  in  5  destination GPR
es_ex  in  1  exception raised upstream
es_payload  in  PAYLOAD_WD  sideband
es_req_inflight  in  1  EX has an accepted request whose instruction is still in EX
data_sram_data_ok  in  1  response valid this cycle
data_sram_rdata  in  32  response data
ws_allowin  in  1  WB accepts
ms_to_ws_valid  out  1  MS presents valid instruction
ms_pc  out  32  registered PC
ms_result  out  32  final result (aligned load data or ALU result)
ms_rf_we  out  4  per-byte GPR write enable
ms_dest  out  5  destination GPR
ms_ex  out  1  exception flag (= registered es_ex)
ms_payload  out  PAYLOAD_WD  registered sideband
ms_valid  out  1  stage occupied
ms_fwd_valid, ms_fwd_stall, ms_fwd_dest[5], ms_fwd_data[32]  out  forwarding/hazard bus (see Optional Feature)
handle_ex  in  1  flush from WB exception/eret

Behaviour:
- Reset: ms_valid=0, buf_valid=0, cancel_cnt=0. All outputs derived from these: ms_to_ws_valid=0, ms_fwd_*=0.
- Capture: when es_to_ms_valid && ms_allowin, register all es_* fields.
- ms_valid: cleared on reset or handle_ex (handle_ex has priority over capture); otherwise loaded with es_to_ms_valid when ms_allowin.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_to_ws_valid = ms_valid && ms_ready_go.
- waiting = ms_valid && ms_mem_req && !ms_ex && !buf_valid.
- live_ok = data_sram_data_ok && cancel_cnt==0.
- ms_ready_go = !ms_mem_req || ms_ex || buf_valid || live_ok.
- Result uses buffered data when buf_valid, otherwise data_sram_rdata.
- Response buffer: when waiting && live_ok && !ws_allowin, latch rdata and set buf_valid. buf_valid clears when the instruction leaves (ms_to_ws_valid && ws_allowin) or on handle_ex.
- Zero-latency path: data_ok can arrive in the same cycle as ws_allowin; the result then passes combinationally with no added latency.
- Cancel counter:
  - data_ok while cancel_cnt>0 decrements it; that rdata is dropped.
  - On handle_ex, increment by (waiting && !live_ok) + es_req_inflight.
  - Simultaneous decrement and increments apply net.
  - Never exceeds MAX_CANCEL; simulation assertion fires on overflow.
- Load alignment (a = ms_alu_result[1:0]):
  - lb/lbu: byte a, sign- or zero-extended.
  - lh/lhu: half a[1], extended.
  - lw: whole word.
  - lwl: rdata shifted left by 8*(3-a); rf_we = 1000/1100/1110/1111 for a=0..3.
  - lwr: rdata shifted right by 8*a; rf_we = 1111/0111/0011/0001 for a=0..3.
  - Non-load: rf_we = {4{gr_we}}; result = alu_result.
- Exceptions: ms_ex suppresses rf_we (forced 0000).
- ms_ex passes through combinationally to CP0 logic.

Optional Feature:
- Macro MS_FWD_EN.
- Defined:
  - ms_fwd_valid = ms_valid && gr_we && !ms_ex && dest!=0.
  - ms_fwd_dest = ms_dest.
  - ms_fwd_data = ms_result.
  - ms_fwd_stall = ms_valid && load && !ms_ready_go, so ID stalls on a pending load.
- Undefined: all ms_fwd_* tied to 0; ID relies on valid/dest scoreboarding.

Decomposition:
- Shared package mem_stage_pkg: LOAD_OP_WD=7, one-hot bit indices (LB..LWR), exccode constants, rf_we encodings.
- Sub-module mem_load_align: purely combinational; inputs rdata, addr_low, load_op, gr_we; outputs result[32], rf_we[4].

Test Plan:
- lw at 0x100, data_ok 3 cycles later with 0xDEADBEEF, ws_allowin=1 -> ms_to_ws_valid rises in the data_ok cycle; result 0xDEADBEEF; rf_we=1111.
- lb a=3, rdata 0x80xxxxxx -> 0xFFFFFF80; lbu -> 0x00000080; lwr a=1, rdata 0x11223344 -> result 0x00112233, rf_we 0111.
- data_ok arrives while ws_allowin=0 for 2 cycles -> buffered value presented unchanged; no second request consumed; buf_valid clears on exit.
- handle_ex while waiting with es_req_inflight=1 -> cancel_cnt=2; next two data_ok dropped; third data_ok delivered to the new load.
- Instruction with es_ex=1 and es_mem_req=1 -> ready_go immediately; ms_ex=1; rf_we=0000.
- With MS_FWD_EN: load waiting -> ms_fwd_stall=1; ALU op to $5 -> ms_fwd_valid=1, dest=5, data=alu_result. Without the macro: all ms_fwd_* = 0.
